// File: rtl/param_shift_serializer.sv
// param_shift_serializer
// Loadable shift register that serialises a frame of WIDTH shift steps.
// A load captures d plus a constant increment and opens a frame; each
// subsequent shift step (left, right or rotate-left) advances the frame
// counter, and the step that completes WIDTH shifts closes the frame and
// raises a one-cycle done pulse. Shifting also works outside a frame, but
// the counter only runs while a frame is open.

module param_shift_serializer #(
   parameter int WIDTH = 8,
   parameter int INC   = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           load,
   input  logic [WIDTH-1:0]               d,
   input  logic [1:0]                     mode,
   input  logic                           shift_en,
   input  logic                           sin,
   output logic                           out,
   output logic [WIDTH-1:0]               q,
   output logic [$clog2(WIDTH+1)-1:0]     cnt,
   output logic                           busy,
   output logic                           done
);

   localparam int CW = $clog2(WIDTH + 1);

   // Increment folded into the register width so the load sum wraps naturally.
   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   // Counter value just before the step that completes the frame.
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_ROTL  = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_done;

   logic             w_step;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_loadValue;

   // A shift step needs an active mode and enable, and a load always wins.
   assign w_step      = shift_en && (mode != MODE_HOLD) && !load;
   assign w_loadValue = d + INC_W;

   // Next register contents for the currently selected shift mode.
   always_comb begin
      w_shifted = r_q;
      case (mode)
         MODE_LEFT:  w_shifted = {r_q[WIDTH-2:0], sin};
         MODE_RIGHT: w_shifted = {sin, r_q[WIDTH-1:1]};
         MODE_ROTL:  w_shifted = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
         default:    w_shifted = r_q;
      endcase
   end

   // Serial output follows the end of the register that leaves first.
   always_comb begin
      out = r_q[WIDTH-1];
      if (mode == MODE_RIGHT) begin
         out = r_q[0];
      end
   end

   // Frame FSM, data register, step counter and done pulse in one block.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (load) begin
            r_q     <= w_loadValue;
            r_cnt   <= '0;
            r_state <= SHIFT;
         end else if (w_step) begin
            r_q <= w_shifted;
            if (r_state == SHIFT) begin
               if (r_cnt == LAST_STEP) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
         end
      end
   end

   assign q    = r_q;
   assign cnt  = r_cnt;
   assign busy = (r_state == SHIFT);
   assign done = r_done;

endmodule

// File: tb/tb_param_shift_serializer.sv
// tb_param_shift_serializer
// Directed scenarios plus a randomized run, all compared against a
// behavioural frame model that tracks the register as an integer value.

module tb_param_shift_serializer;

   localparam int W   = 8;
   localparam int INC = 1;
   localparam int MOD = 256;
   localparam int CW  = $clog2(W + 1);

   logic          clk;
   logic          reset;
   logic          load;
   logic [W-1:0]  d;
   logic [1:0]    mode;
   logic          shift_en;
   logic          sin;
   logic          out;
   logic [W-1:0]  q;
   logic [CW-1:0] cnt;
   logic          busy;
   logic          done;

   int passCount  = 0;
   int checkCount = 0;

   // Behavioural model state: register value, shifts in the open frame,
   // whether a frame is open, and whether the previous edge finished a frame.
   int mQ     = 0;
   int mSteps = 0;
   bit mFrame = 1'b0;
   bit mDone  = 1'b0;

   param_shift_serializer #(.WIDTH(W), .INC(INC)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .d        (d),
      .mode     (mode),
      .shift_en (shift_en),
      .sin      (sin),
      .out      (out),
      .q        (q),
      .cnt      (cnt),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of one rising edge, written in terms of arithmetic on the value.
   task automatic modelEdge();
      if (reset) begin
         mQ = 0; mSteps = 0; mFrame = 1'b0; mDone = 1'b0;
      end else begin
         mDone = 1'b0;
         if (load) begin
            mQ = (int'(d) + INC) % MOD;
            mSteps = 0;
            mFrame = 1'b1;
         end else if (shift_en && mode != 2'd0) begin
            case (mode)
               2'd1: mQ = (mQ * 2 + int'(sin)) % MOD;
               2'd2: mQ = mQ / 2 + int'(sin) * (MOD / 2);
               default: mQ = (mQ * 2) % MOD + mQ / (MOD / 2);
            endcase
            if (mFrame) begin
               mSteps = mSteps + 1;
               if (mSteps == W) begin
                  mSteps = 0;
                  mFrame = 1'b0;
                  mDone  = 1'b1;
               end
            end
         end
      end
   endtask

   function automatic int modelOut();
      if (mode == 2'd2) return mQ % 2;
      return mQ / (MOD / 2);
   endfunction

   // Drive one cycle's worth of inputs, leaving out time to settle.
   task automatic applyStimulus(input bit rst, input bit ld, input int data,
                                input int md, input bit en, input bit s);
      reset    = rst;
      load     = ld;
      d        = W'(data);
      mode     = 2'(md);
      shift_en = en;
      sin      = s;
      #1;
   endtask

   // Advance one clock edge, updating the model alongside the DUT.
   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1, 1, 'h55, 1, 1, 1);
      tick();
      tick();
      checkCount++;
      if (q !== 8'h00) $display("[TB] FAIL reset_q actual=%h required=00", q);
      else passCount++;
      checkCount++;
      if (cnt !== '0) $display("[TB] FAIL reset_cnt actual=%0d required=0", cnt);
      else passCount++;
      checkCount++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("[TB] FAIL reset_flags actual busy=%b done=%b required 0 0", busy, done);
      else passCount++;
      checkCount++;
      if (out !== 1'b0) $display("[TB] FAIL reset_out actual=%b required=0", out);
      else passCount++;
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_serialise();
      bit expBits [8] = '{1, 0, 1, 0, 1, 0, 1, 1};
      int doneSeen = 0;
      applyStimulus(0, 1, 'hAA, 0, 0, 0);
      tick();
      checkCount++;
      if (q !== 8'hAB || busy !== 1'b1 || cnt !== '0)
         $display("[TB] FAIL serial_load actual q=%h busy=%b cnt=%0d required q=ab busy=1 cnt=0", q, busy, cnt);
      else passCount++;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 0);
         checkCount++;
         if (out !== expBits[i])
            $display("[TB] FAIL serial_out%0d actual=%b required=%b", i, out, expBits[i]);
         else passCount++;
         tick();
         if (done === 1'b1) doneSeen++;
      end
      checkCount++;
      if (q !== 8'h00 || done !== 1'b1 || busy !== 1'b0 || cnt !== '0)
         $display("[TB] FAIL serial_end actual q=%h done=%b busy=%b cnt=%0d required q=00 done=1 busy=0 cnt=0",
                  q, done, busy, cnt);
      else passCount++;
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkCount++;
      if (done !== 1'b0 || doneSeen != 1)
         $display("[TB] FAIL serial_done_width actual done=%b pulses=%0d required done=0 pulses=1", done, doneSeen);
      else passCount++;
   endtask

   task automatic test_wrap();
      applyStimulus(0, 1, 'hFF, 0, 0, 0);
      tick();
      checkCount++;
      if (q !== 8'h00 || busy !== 1'b1)
         $display("[TB] FAIL wrap_load actual q=%h busy=%b required q=00 busy=1", q, busy);
      else passCount++;
   endtask

   task automatic test_rotate();
      int doneSeen = 0;
      applyStimulus(0, 1, 'h80, 0, 0, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 0, 3, 1, $urandom_range(0, 1));
         tick();
         if (done === 1'b1) doneSeen++;
         if (i == 0) begin
            checkCount++;
            if (q !== 8'h03) $display("[TB] FAIL rotate_step1 actual=%h required=03", q);
            else passCount++;
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      if (done === 1'b1) doneSeen++;
      checkCount++;
      if (q !== 8'h81 || doneSeen != 1 || busy !== 1'b0)
         $display("[TB] FAIL rotate_end actual q=%h pulses=%0d busy=%b required q=81 pulses=1 busy=0", q, doneSeen, busy);
      else passCount++;
   endtask

   task automatic test_stall_restart();
      int doneSeen = 0;
      applyStimulus(0, 1, 'h0F, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 1);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, $urandom_range(0, 3), 0, 1);
         tick();
         if (done === 1'b1) doneSeen++;
      end
      checkCount++;
      if (cnt !== 4'd3 || q !== 8'h87 || busy !== 1'b1)
         $display("[TB] FAIL stall_hold actual q=%h cnt=%0d busy=%b required q=87 cnt=3 busy=1", q, cnt, busy);
      else passCount++;
      applyStimulus(0, 1, 'h10, 1, 1, 0);
      tick();
      checkCount++;
      if (q !== 8'h11 || cnt !== '0 || busy !== 1'b1)
         $display("[TB] FAIL restart_load actual q=%h cnt=%0d busy=%b required q=11 cnt=0 busy=1", q, cnt, busy);
      else passCount++;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 2, 1, 0);
         tick();
         if (done === 1'b1) doneSeen++;
      end
      checkCount++;
      if (doneSeen != 0 || cnt !== 4'd5)
         $display("[TB] FAIL restart_no_done actual pulses=%0d cnt=%0d required pulses=0 cnt=5", doneSeen, cnt);
      else passCount++;
   endtask

   task automatic test_mid_reset();
      int doneSeen = 0;
      applyStimulus(0, 1, 'h3C, 0, 0, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 1);
         tick();
      end
      applyStimulus(1, 0, 0, 1, 1, 1);
      tick();
      checkCount++;
      if (q !== 8'h00 || cnt !== '0 || busy !== 1'b0 || done !== 1'b0)
         $display("[TB] FAIL midreset actual q=%h cnt=%0d busy=%b done=%b required q=00 cnt=0 busy=0 done=0",
                  q, cnt, busy, done);
      else passCount++;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 0);
         tick();
         if (done === 1'b1) doneSeen++;
      end
      checkCount++;
      if (doneSeen != 0 || cnt !== '0)
         $display("[TB] FAIL midreset_idle actual pulses=%0d cnt=%0d required pulses=0 cnt=0", doneSeen, cnt);
      else passCount++;
   endtask

   task automatic test_load_on_final();
      applyStimulus(0, 1, 'h21, 0, 0, 0);
      tick();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 0, 0, 3, 1, 0);
         tick();
      end
      applyStimulus(0, 1, 'h40, 1, 1, 1);
      tick();
      checkCount++;
      if (q !== 8'h41 || cnt !== '0 || busy !== 1'b1 || done !== 1'b0)
         $display("[TB] FAIL final_load actual q=%h cnt=%0d busy=%b done=%b required q=41 cnt=0 busy=1 done=0",
                  q, cnt, busy, done);
      else passCount++;
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         applyStimulus(r < 2, r >= 2 && r < 12, $urandom_range(0, 255),
                       $urandom_range(0, 3), $urandom_range(0, 9) < 8, $urandom_range(0, 1));
         checkCount++;
         if (int'(out) != modelOut())
            $display("[TB] FAIL rand_out cyc=%0d actual=%b required=%0d", i, out, modelOut());
         else passCount++;
         tick();
         checkCount++;
         if (int'(q) != mQ || int'(cnt) != mSteps || busy !== mFrame || done !== mDone)
            $display("[TB] FAIL rand_state cyc=%0d actual q=%h cnt=%0d busy=%b done=%b required q=%h cnt=%0d busy=%b done=%b",
                     i, q, cnt, busy, done, mQ[7:0], mSteps, mFrame, mDone);
         else passCount++;
      end
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      test_reset();
      test_serialise();
      test_wrap();
      test_rotate();
      test_stall_restart();
      test_mid_reset();
      test_load_on_final();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/param_shift_serializer.md
PARAM_SHIFT_SERIALIZER -- requirements
Module: param_shift_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have parameter INC, default 1, constant added to d on load, taken modulo 2^WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port load  input  1  parallel-load request; starts a new frame.
REQ-006 SHALL have port d  input  WIDTH  parallel load data.
REQ-007 SHALL have port mode  input  2  00 hold, 01 shift left, 10 shift right, 11 rotate left.
REQ-008 SHALL have port shift_en  input  1  advance one shift step when high.
REQ-009 SHALL have port sin  input  1  serial input bit inserted by shift-left and shift-right.
REQ-010 SHALL have port out  output  1  serial output bit.
REQ-011 SHALL have port q  output  WIDTH  current register contents.
REQ-012 SHALL have port cnt  output  $clog2(WIDTH+1)  shifts completed in the current frame.
REQ-013 SHALL have port busy  output  1  high while a frame is in progress.
REQ-014 SHALL have port done  output  1  single-cycle frame-complete pulse.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-016 SHALL give update priority reset > load > shift step.
REQ-017 SHALL, on load in any state, set q to (d + INC) mod 2^WIDTH, clear cnt, and enter SHIFT.
REQ-018 SHALL treat a cycle as a shift step when shift_en=1, mode≠00, and load=0.
REQ-019 SHALL, on a shift-left step, set q to {q[WIDTH-2:0], sin}.
REQ-020 SHALL, on a shift-right step, set q to {sin, q[WIDTH-1:1]}.
REQ-021 SHALL, on a rotate-left step, set q to {q[WIDTH-2:0], q[WIDTH-1]}; sin is ignored.
REQ-022 SHALL hold q when mode=00 or shift_en=0; cnt SHALL NOT advance in those cycles.
REQ-023 SHALL perform shift steps in IDLE as well as in SHIFT; cnt SHALL stay 0 in IDLE.
REQ-024 SHALL drive out combinationally as q[0] when mode=10, and as q[WIDTH-1] for all other modes.
REQ-025 SHALL increment cnt on each shift step in SHIFT.
REQ-026 SHALL, on the shift step that takes cnt to WIDTH, return to IDLE, clear cnt, and assert done in the following cycle only.
REQ-027 SHALL drive busy=1 exactly when the state is SHIFT.
REQ-028 SHALL, on load during the final shift step, take the load: no done pulse, cnt=0, state SHIFT.
REQ-029 SHALL allow mode to change mid-frame; every shift step counts regardless of mode.

Reset
REQ-030 SHALL, when reset=1 at a rising clk, set q=0, cnt=0, state IDLE, busy=0, done=0; out then reads 0.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no done pulse.
REQ-032 SHALL hold reset values while reset stays high, regardless of load and shift_en.

Verification (WIDTH=8, INC=1)
REQ-033 SHALL verify reset: assert reset for 2 cycles with load=1, d=0x55 -> q=0x00, cnt=0, busy=0, done=0, out=0.
REQ-034 SHALL verify MSB-first serialisation: load d=0xAA, then mode=01, sin=0, shift_en=1 for 8 cycles -> q=0xAB after load; out reads 1,0,1,0,1,0,1,1 before each step; q=0x00 at the end; done pulses for 1 cycle after step 8; busy then falls.
REQ-035 SHALL verify load wrap-around: load d=0xFF -> q=0x00, busy=1.
REQ-036 SHALL verify rotate: load d=0x80, then mode=11 for 8 steps -> q=0x81 at the end; after step 1 q=0x03; done pulses once.
REQ-037 SHALL verify stall and restart: load 0x0F, 3 steps, shift_en=0 for 4 cycles -> q and cnt=3 held; then load 0x10 -> q=0x11, cnt=0, and no done is ever issued for the first frame.
REQ-038 SHALL verify mid-frame reset: after 5 steps assert reset -> q=0x00, cnt=0, busy=0, and done is never asserted.
